// File: rtl/zynq_pspl_pkg.sv
// Shared constants and types for the PS-PL AXI4-Lite register-bank slave.
package zynq_pspl_pkg;
  localparam int         ADDR_LSB          = 2;
  localparam int         OPT_MEM_ADDR_BITS = 4;
  localparam logic [1:0] RESP_OKAY         = 2'b00;

  typedef logic [4:0] reg_index_t;

  typedef struct packed {
    reg_index_t  index;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;
endpackage

// File: rtl/pspl_axi_wr_ctrl.sv
// AXI4-Lite write channel: independent AW/W capture, commit gating and B response.
module pspl_axi_wr_ctrl
  import zynq_pspl_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  input  logic              bready,
  output logic              commit,
  output wr_req_t           req
);
  logic aw_held, w_held, aw_held_nxt, w_held_nxt;
  logic aw_hs, w_hs;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  // A held pair may only retire once the slot for its B response is free.
  assign commit = aw_held & w_held & (~bvalid | bready);

  always_comb begin
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    if (commit) begin
      aw_held_nxt = 1'b0;
      w_held_nxt  = 1'b0;
    end else begin
      if (aw_hs) aw_held_nxt = 1'b1;
      if (w_hs)  w_held_nxt  = 1'b1;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      req     <= '0;
    end else begin
      aw_held <= aw_held_nxt;
      w_held  <= w_held_nxt;
      awready <= ~aw_held_nxt;
      wready  <= ~w_held_nxt;
      if (aw_hs) req.index <= awaddr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
      if (w_hs) begin
        req.data <= wdata;
        req.strb <= wstrb;
      end
      if (commit)      bvalid <= 1'b1;
      else if (bready) bvalid <= 1'b0;
    end
  end

  logic unused_addr;
  assign unused_addr = ^awaddr[ADDR_LSB-1:0];
endmodule

// File: rtl/pspl_axi_lite_slave.sv
// PS-PL register bank: 32 writable words out on slv_wires, reads served from an external mux.
module pspl_axi_lite_slave
  import zynq_pspl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int NUM_REGS           = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   reg_data_out,
  output logic [NUM_REGS*32-1:0]          slv_wires,
  output logic [NUM_REGS-1:0]             wr_pulse
);
  logic    commit;
  wr_req_t req;
  logic [NUM_REGS-1:0][31:0] regs;

  pspl_axi_wr_ctrl #(.ADDR_W(C_S_AXI_ADDR_WIDTH)) u_wr (
    .gclk    (S_AXI_ACLK),
    .grst_n  (S_AXI_ARESETN),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .commit  (commit),
    .req     (req)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [31:0] q;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) q <= '0;
      else if (commit && req.index == reg_index_t'(i))
        for (int k = 0; k < 4; k++)
          if (req.strb[k]) q[8*k +: 8] <= req.data[8*k +: 8];
    end
    assign regs[i] = q;
  end

  assign slv_wires   = regs;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wr_pulse <= '0;
    else                wr_pulse <= commit ? (NUM_REGS'(1) << req.index) : '0;
  end

  // Read: address is exported on the handshake edge, the mux result is sampled one edge later.
  logic rd_busy, rd_busy_nxt, rd_fetch, ar_hs, r_hs;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

  always_comb begin
    rd_busy_nxt = rd_busy;
    if (ar_hs)     rd_busy_nxt = 1'b1;
    else if (r_hs) rd_busy_nxt = 1'b0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_busy       <= 1'b0;
      rd_fetch      <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      axi_araddr    <= '0;
    end else begin
      rd_busy       <= rd_busy_nxt;
      rd_fetch      <= ar_hs;
      S_AXI_ARREADY <= ~rd_busy_nxt;
      if (ar_hs) axi_araddr <= S_AXI_ARADDR;
      if (rd_fetch) begin
        S_AXI_RDATA  <= reg_data_out;
        S_AXI_RVALID <= 1'b1;
      end else if (r_hs) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};
endmodule

// File: tb/tb_pspl_axi_lite_slave.sv
// Scoreboard bench for pspl_axi_lite_slave: writes/reads queue their expectations, responses pop them.
module tb_pspl_axi_lite_slave;
  localparam int NR = 32;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [6:0]        awaddr = '0, araddr = '0, axi_araddr;
  logic [2:0]        awprot = '0, arprot = '0;
  logic              awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic              arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0]       wdata = '0, rdata, reg_data_out;
  logic [3:0]        wstrb = '0;
  logic [1:0]        bresp, rresp;
  logic [NR*32-1:0]  slv_wires;
  logic [NR-1:0]     wr_pulse;

  always #5 clk = ~clk;

  pspl_axi_lite_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .axi_araddr(axi_araddr), .reg_data_out(reg_data_out),
    .slv_wires(slv_wires), .wr_pulse(wr_pulse)
  );

  // External read mux: slot 4 is a fixed pattern, every other slot reads back its register.
  assign reg_data_out = (axi_araddr[6:2] == 5'd4) ? 32'hA5A5A5A5 : slv_wires[32*axi_araddr[6:2] +: 32];

  typedef struct { int idx; logic [31:0] val; } bexp_t;
  bexp_t       exp_b_q[$];
  logic [31:0] exp_r_q[$];
  logic [31:0] model [NR];
  int n_assert = 0, n_fail = 0, b_hs_cnt = 0;
  int pulse_cnt [NR];

  initial for (int i = 0; i < NR; i++) begin model[i] = '0; pulse_cnt[i] = 0; end

  always @(negedge clk) if (rst_n) begin
    if (bvalid && bready) b_hs_cnt++;
    for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  function automatic logic [31:0] word(input int i);
    return slv_wires[32*i +: 32];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_issue(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, input int w_lead);
    int idx; logic [31:0] nv; bit aw_go, w_go; bexp_t e;
    idx = int'(a[6:2]);
    nv = model[idx];
    for (int k = 0; k < 4; k++) if (s[k]) nv[8*k +: 8] = d[8*k +: 8];
    model[idx] = nv; e.idx = idx; e.val = nv; exp_b_q.push_back(e);
    wdata = d; wstrb = s; wvalid = 1;
    for (int c = 0; c < w_lead; c++) begin
      w_go = wvalid && wready; tick(); if (w_go) wvalid = 0;
    end
    awaddr = a; awvalid = 1;
    for (int c = 0; c < 30 && (awvalid || wvalid); c++) begin
      aw_go = awvalid && awready; w_go = wvalid && wready;
      tick();
      if (aw_go) awvalid = 0;
      if (w_go) wvalid = 0;
    end
    n_assert++;
    if (awvalid || wvalid) begin
      n_fail++;
      $display("FAIL write_issue %h: aw pending %0b w pending %0b, required both accepted", a, awvalid, wvalid);
      awvalid = 0; wvalid = 0;
    end
  endtask

  task automatic wait_bvalid(input string tag);
    for (int c = 0; c < 40 && !bvalid; c++) tick();
    n_assert++;
    if (bvalid !== 1'b1) begin n_fail++; $display("FAIL %s bvalid_timeout: got %b required 1", tag, bvalid); end
  endtask

  task automatic accept_b(input string tag);
    bexp_t e;
    n_assert++;
    if (exp_b_q.size() == 0) begin
      n_fail++; $display("FAIL %s b_unexpected: got B response, required none queued", tag);
    end else begin
      e = exp_b_q.pop_front();
      if (word(e.idx) !== e.val) begin
        n_fail++; $display("FAIL %s reg%0d: got %h required %h", tag, e.idx, word(e.idx), e.val);
      end
    end
    n_assert++;
    if (bresp !== 2'b00) begin n_fail++; $display("FAIL %s bresp: got %b required 00", tag, bresp); end
    bready = 1; tick();
  endtask

  task automatic do_read(input logic [6:0] a, input int hold);
    logic [31:0] e, held;
    e = (a[6:2] == 5'd4) ? 32'hA5A5A5A5 : model[a[6:2]];
    exp_r_q.push_back(e);
    araddr = a; arvalid = 1; rready = 0;
    for (int c = 0; c < 20 && !arready; c++) tick();
    n_assert++;
    if (arready !== 1'b1) begin
      n_fail++; $display("FAIL rd %h arready_timeout: got %b required 1", a, arready);
      arvalid = 0; void'(exp_r_q.pop_back()); return;
    end
    tick(); arvalid = 0;
    n_assert++;
    if (axi_araddr !== a || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_addr: got araddr %h rvalid %b required %h 0", axi_araddr, rvalid, a);
    end
    tick();
    n_assert++;
    if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_latency %h: got rvalid %b required 1", a, rvalid); end
    for (int c = 0; c < 10 && !rvalid; c++) tick();
    held = rdata;
    for (int d = 0; d < hold; d++) begin
      tick();
      n_assert++;
      if (rvalid !== 1'b1 || rdata !== held || arready !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_hold %h: got rvalid %b rdata %h arready %b required 1 %h 0", a, rvalid, rdata, arready, held);
      end
    end
    e = exp_r_q.pop_front();
    n_assert++;
    if (rdata !== e || rresp !== 2'b00) begin
      n_fail++; $display("FAIL rd_data %h: got %h resp %b required %h resp 00", a, rdata, rresp, e);
    end
    rready = 1; tick(); rready = 0;
    n_assert++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_done %h: got rvalid %b required 0", a, rvalid); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_hs: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_assert++;
    if (rdata !== '0 || axi_araddr !== '0 || wr_pulse !== '0 || slv_wires !== '0) begin
      n_fail++; $display("FAIL reset_data: got rdata %h araddr %h pulse %h required all 0", rdata, axi_araddr, wr_pulse);
    end
    @(negedge clk) rst_n = 1;
    tick();
    n_assert++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_same_cycle();
    bready = 1;
    write_issue(7'h7C, 32'hDEADBEEF, 4'hF, 0);
    n_assert++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL t1_bvalid_early: got %b required 0", bvalid); end
    tick();
    n_assert++;
    if (bvalid !== 1'b1) begin n_fail++; $display("FAIL t1_bvalid: got %b required 1", bvalid); end
    n_assert++;
    if (wr_pulse !== 32'h8000_0000) begin n_fail++; $display("FAIL t1_pulse: got %h required 80000000", wr_pulse); end
    n_assert++;
    if (slv_wires[1023:992] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL t1_reg31: got %h required deadbeef", slv_wires[1023:992]);
    end
    accept_b("t1");
    n_assert++;
    if (bvalid !== 1'b0 || wr_pulse !== '0) begin
      n_fail++; $display("FAIL t1_after: got bvalid %b pulse %h required 0 0", bvalid, wr_pulse);
    end
  endtask

  task automatic test_w_first();
    int base;
    bready = 1; base = b_hs_cnt;
    write_issue(7'h08, 32'h12345678, 4'b0101, 3);
    wait_bvalid("t2");
    n_assert++;
    if (word(2) !== 32'h00340078) begin n_fail++; $display("FAIL t2_reg2: got %h required 00340078", word(2)); end
    accept_b("t2");
    repeat (4) tick();
    n_assert++;
    if (b_hs_cnt - base !== 1) begin n_fail++; $display("FAIL t2_b_count: got %0d required 1", b_hs_cnt - base); end
  endtask

  task automatic test_b_backpressure();
    int base;
    bready = 0; base = b_hs_cnt;
    write_issue(7'h20, 32'h11111111, 4'hF, 0);
    wait_bvalid("t3");
    write_issue(7'h24, 32'h22222222, 4'hF, 0);
    for (int c = 0; c < 5; c++) begin
      n_assert++;
      if (bvalid !== 1'b1 || word(9) !== 32'h0) begin
        n_fail++; $display("FAIL t3_hold: got bvalid %b reg9 %h required 1 00000000", bvalid, word(9));
      end
      tick();
    end
    accept_b("t3a");
    n_assert++;
    if (bvalid !== 1'b1 || word(9) !== 32'h22222222 || wr_pulse !== (32'h1 << 9)) begin
      n_fail++; $display("FAIL t3_second_commit: got bvalid %b reg9 %h pulse %h required 1 22222222 00000200", bvalid, word(9), wr_pulse);
    end
    accept_b("t3b");
    bready = 0;
    tick();
    n_assert++;
    if (b_hs_cnt - base !== 2 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL t3_b_count: got %0d bvalid %b required 2 0", b_hs_cnt - base, bvalid);
    end
  endtask

  task automatic test_read();
    do_read(7'h10, 4);
    repeat (2) tick();
    n_assert++;
    if (axi_araddr !== 7'h10) begin n_fail++; $display("FAIL t4_araddr_hold: got %h required 10", axi_araddr); end
  endtask

  task automatic test_back_to_back();
    int snap [NR];
    for (int i = 0; i < NR; i++) snap[i] = pulse_cnt[i];
    bready = 1;
    fork
      for (int i = 0; i < NR; i++) write_issue(7'(i*4), 32'hC0DE0000 | i, 4'hF, 0);
      for (int i = 0; i < NR; i++) begin wait_bvalid("t5"); accept_b("t5"); end
      for (int j = 0; j < 6; j++) do_read(7'h10, j % 3);
    join
    for (int i = 0; i < NR; i += 5) do_read(7'(i*4), 0);
    repeat (2) tick();
    for (int i = 0; i < NR; i++) begin
      n_assert++;
      if (pulse_cnt[i] - snap[i] !== 1) begin
        n_fail++; $display("FAIL t5_pulse%0d: got %0d pulses required 1", i, pulse_cnt[i] - snap[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    bready = 0; rready = 0;
    awaddr = 7'h0C; wdata = 32'h5555AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 7'h14; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (2) tick();
    n_assert++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || word(3) !== 32'h5555AAAA) begin
      n_fail++; $display("FAIL t6_pending: got bvalid %b rvalid %b reg3 %h required 1 1 5555aaaa", bvalid, rvalid, word(3));
    end
    #2 rst_n = 0;
    #1;
    n_assert++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b0 || rdata !== '0) begin
      n_fail++; $display("FAIL t6_async_hs: got %b rdata %h required 00000 0", {bvalid, rvalid, awready, wready, arready}, rdata);
    end
    n_assert++;
    if (slv_wires !== '0 || wr_pulse !== '0 || axi_araddr !== '0) begin
      n_fail++; $display("FAIL t6_async_regs: got reg3 %h pulse %h araddr %h required 0", word(3), wr_pulse, axi_araddr);
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
    exp_b_q.delete(); exp_r_q.delete();
    @(negedge clk) rst_n = 1;
    bready = 1; rready = 1; seen = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (bvalid || rvalid) seen = 1; end
    rready = 0;
    n_assert++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL t6_no_response: got response %b required 0", seen); end
    n_assert++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL t6_ready: got %b required 111", {awready, wready, arready});
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_b_backpressure();
    test_read();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
